aes_inv_round_stage: RTL and testbench

Single-cycle registered stage of the AES inverse cipher (FIPS-197). It applies InvShiftRows, then InvSubBytes, then AddRoundKey to a 128-bit state. A bypass mode performs AddRoundKey alone, for the initial key whitening. Instances chain to form the decryption datapath for AES-128/192/256; InvMixColumns and key expansion sit outside this block.

---
 rtl/aes_inv_round_stage.sv | 120 ++++++++++++
 tb/tb_aes_inv_round_stage.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/aes_inv_round_stage.sv
// AES inverse round stage: InvShiftRows, InvSubBytes, AddRoundKey.
// Registered result; bypass mode performs AddRoundKey alone.

module aes_inv_sbox (
  input  logic [7:0] din,
  output logic [7:0] dout
);

  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  logic [10:0] msb;

  assign msb  = 11'd2047 - {din, 3'b000};
  assign dout = INV_SBOX[msb -: 8];

endmodule

module aes_inv_shift_rows (
  input  logic [127:0] din,
  output logic [127:0] dout
);

  // Row r of the output takes column (c - r) mod 4 of the input.
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      localparam int DST = 4 * c + r;
      localparam int SRC = 4 * ((c - r + 4) % 4) + r;
      assign dout[127-8*DST -: 8] = din[127-8*SRC -: 8];
    end
  end

endmodule

module aes_inv_sub_bytes (
  input  logic [127:0] din,
  output logic [127:0] dout
);

  for (genvar k = 0; k < 16; k++) begin : g_byte
    aes_inv_sbox u_sbox (
      .din  (din[127-8*k -: 8]),
      .dout (dout[127-8*k -: 8])
    );
  end

endmodule

module aes_add_round_key (
  input  logic [127:0] din,
  input  logic [127:0] key,
  output logic [127:0] dout
);

  assign dout = din ^ key;

endmodule

module aes_inv_round_stage (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         ark_only,
  input  logic [127:0] state_in,
  input  logic [127:0] round_key,
  output logic [127:0] state_out,
  output logic         out_valid
);

  logic [127:0] isr_q;
  logic [127:0] isb_q;
  logic [127:0] ark_in;
  logic [127:0] result;

  aes_inv_shift_rows u_isr (
    .din  (state_in),
    .dout (isr_q)
  );

  aes_inv_sub_bytes u_isb (
    .din  (isr_q),
    .dout (isb_q)
  );

  assign ark_in = ark_only ? state_in : isb_q;

  aes_add_round_key u_ark (
    .din  (ark_in),
    .key  (round_key),
    .dout (result)
  );

  // Capture the result on enabled cycles; hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_out <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= en;
      if (en) state_out <= result;
    end
  end

endmodule

// File: tb/tb_aes_inv_round_stage.sv
// Directed self-checking bench for aes_inv_round_stage.
// Hand-computed vectors from FIPS-197 plus an inverse S-box sweep.

module tb_aes_inv_round_stage;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic         ark_only;
  logic [127:0] state_in;
  logic [127:0] round_key;
  logic [127:0] state_out;
  logic         out_valid;

  int checks   = 0;
  int failures = 0;

  localparam logic [127:0] V_ZERO_OUT = 128'h52525252525252525252525252525252;
  localparam logic [127:0] V_C2_IN    = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] V_C2_KEY   = 128'ha4970a331a78dc09c418c271e3a41d5d;
  localparam logic [127:0] V_C2_START = 128'h793e76979c3403e9aab7b2d10fa96ccc;
  localparam logic [127:0] V_ISR      = 128'h79a9b2e99c3e6cd1aa3476cc0fb70397;
  localparam logic [127:0] V_ISB      = 128'hafb73eeb1cd1b85162280f27fb20d585;
  localparam logic [127:0] V_ISB_N    = 128'h5048c114e32e47ae9dd7f0d804df2a7a;

  logic [2047:0] ref_tbl;

  always #5 clk = ~clk;

  aes_inv_round_stage dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .ark_only  (ark_only),
    .state_in  (state_in),
    .round_key (round_key),
    .state_out (state_out),
    .out_valid (out_valid)
  );

  task automatic drive(input logic e, input logic a,
                       input logic [127:0] s, input logic [127:0] k);
    en        = e;
    ark_only  = a;
    state_in  = s;
    round_key = k;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    drive(1'b1, 1'b0, V_C2_IN, V_C2_KEY);
    step();
    step();
    checks++;
    if (state_out !== 128'h0) begin
      failures++;
      $display("FAIL reset_state got=%h exp=0", state_out);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_valid got=%b exp=0", out_valid);
    end
    rst = 1'b0;
  endtask

  task automatic test_zero_full;
    drive(1'b1, 1'b0, 128'h0, 128'h0);
    step();
    checks++;
    if (state_out !== V_ZERO_OUT) begin
      failures++;
      $display("FAIL zero_full got=%h exp=%h", state_out, V_ZERO_OUT);
    end
    checks++;
    if (out_valid !== 1'b1) begin
      failures++;
      $display("FAIL zero_valid got=%b exp=1", out_valid);
    end
  endtask

  task automatic test_bypass;
    drive(1'b1, 1'b1, V_C2_IN, V_C2_KEY);
    step();
    checks++;
    if (state_out !== V_C2_START) begin
      failures++;
      $display("FAIL bypass got=%h exp=%h", state_out, V_C2_START);
    end
  endtask

  task automatic test_shift_sub;
    drive(1'b1, 1'b0, V_C2_START, 128'h0);
    #1;
    checks++;
    if (dut.u_isr.dout !== V_ISR) begin
      failures++;
      $display("FAIL isr_block got=%h exp=%h", dut.u_isr.dout, V_ISR);
    end
    step();
    checks++;
    if (state_out !== V_ISB) begin
      failures++;
      $display("FAIL shift_sub got=%h exp=%h", state_out, V_ISB);
    end
    drive(1'b1, 1'b0, V_C2_START, {128{1'b1}});
    step();
    checks++;
    if (state_out !== V_ISB_N) begin
      failures++;
      $display("FAIL shift_sub_ones got=%h exp=%h", state_out, V_ISB_N);
    end
  endtask

  task automatic test_back_to_back;
    logic [127:0] exp_q [3];
    exp_q[0] = V_ZERO_OUT;
    exp_q[1] = V_C2_START;
    exp_q[2] = V_ISB;
    drive(1'b1, 1'b0, 128'h0, 128'h0);
    step();
    checks++;
    if (state_out !== exp_q[0] || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL stream0 got=%h/%b exp=%h/1", state_out, out_valid, exp_q[0]);
    end
    drive(1'b1, 1'b1, V_C2_IN, V_C2_KEY);
    step();
    checks++;
    if (state_out !== exp_q[1] || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL stream1 got=%h/%b exp=%h/1", state_out, out_valid, exp_q[1]);
    end
    drive(1'b1, 1'b0, V_C2_START, 128'h0);
    step();
    checks++;
    if (state_out !== exp_q[2] || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL stream2 got=%h/%b exp=%h/1", state_out, out_valid, exp_q[2]);
    end
    drive(1'b0, 1'b1, V_C2_IN, V_C2_KEY);
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (state_out !== V_ISB || out_valid !== 1'b0) begin
        failures++;
        $display("FAIL hold%0d got=%h/%b exp=%h/0", i, state_out, out_valid, V_ISB);
      end
    end
  endtask

  task automatic test_reset_midstream;
    drive(1'b1, 1'b1, V_C2_IN, V_C2_KEY);
    step();
    rst = 1'b1;
    drive(1'b1, 1'b0, 128'h0, 128'h0);
    step();
    checks++;
    if (state_out !== 128'h0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid got=%h/%b exp=0/0", state_out, out_valid);
    end
    rst = 1'b0;
    step();
    checks++;
    if (state_out !== V_ZERO_OUT || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL post_reset got=%h/%b exp=%h/1", state_out, out_valid, V_ZERO_OUT);
    end
  endtask

  task automatic test_sbox_sweep;
    logic [7:0]   v;
    logic [7:0]   e;
    logic [127:0] exp_blk;
    int           bad;
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      v = i[7:0];
      e = ref_tbl[2047-8*i -: 8];
      exp_blk = {16{e}};
      drive(1'b1, 1'b0, {16{v}}, 128'h0);
      step();
      checks++;
      if (state_out !== exp_blk) begin
        failures++;
        bad++;
        if (bad < 8)
          $display("FAIL sbox_%02h got=%h exp=%h", v, state_out, exp_blk);
      end
    end
  endtask

  initial begin
    ref_tbl = {
      128'h52096ad53036a538bf40a39e81f3d7fb,
      128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e,
      128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692,
      128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506,
      128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673,
      128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b,
      128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f,
      128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961,
      128'h172b047eba77d626e169146355210c7d
    };
    rst = 1'b1;
    drive(1'b0, 1'b0, 128'h0, 128'h0);
    test_reset();
    test_zero_full();
    test_bypass();
    test_shift_sub();
    test_back_to_back();
    test_reset_midstream();
    test_sbox_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
